// File: rtl/dt1_lsu_pkg.sv
// dt1_lsu_pkg: shared state encoding and MemWrite/LoadSize codes for the load/store unit
package dt1_lsu_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, RESP = 2'b10, DONE = 2'b11} state_t;
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_SB   = 2'b01;
  localparam logic [1:0] MEM_SH   = 2'b10;
  localparam logic [1:0] MEM_SW   = 2'b11;
  localparam logic [2:0] LS_LB    = 3'b000;
  localparam logic [2:0] LS_LH    = 3'b001;
  localparam logic [2:0] LS_LW    = 3'b010;
  localparam logic [2:0] LS_LBU   = 3'b100;
  localparam logic [2:0] LS_LHU   = 3'b101;
endpackage

// File: rtl/dt1_lsu_align.sv
// dt1_lsu_align: store strobes/lane replication and load byte/half extraction with extension
module dt1_lsu_align
  import dt1_lsu_pkg::*;
(
  input  logic [1:0]  mem_write_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [2:0]  ld_size_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_i[{ld_addr_i, 3'b000} +: 8];
    h = rdata_i[{ld_addr_i[1], 4'b0000} +: 16];
    wstrb_o = mem_write_i == MEM_SW ? 4'b1111 :
              mem_write_i == MEM_SH ? 4'b0011 << st_addr_i :
              mem_write_i == MEM_SB ? 4'b0001 << st_addr_i : 4'b0000;
    wdata_o = mem_write_i == MEM_SB ? {4{wdata_i[7:0]}} :
              mem_write_i == MEM_SH ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o = ld_size_i == LS_LB  ? {{24{b[7]}}, b} :
              ld_size_i == LS_LH  ? {{16{h[15]}}, h} :
              ld_size_i == LS_LBU ? {24'h0, b} :
              ld_size_i == LS_LHU ? {16'h0, h} : rdata_i;
  end
endmodule

// File: rtl/dt1_lsu.sv
// dt1_lsu: single-beat data-memory load/store unit with stall, misalign and bus-error handling
module dt1_lsu
  import dt1_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
)(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      MemWriteM,
  input  logic            LoadM,
  input  logic [2:0]      LoadSizeM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic            FlushM,
  output logic            StallM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            done_o,
  output logic            MisalignM,
  output logic            BusErrM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] a_q;
  logic [2:0] size_q;
  logic [XLEN-1:0] rdata_q, mem_addr_q, mem_wdata_q, st_wdata, ld_data;
  logic [3:0] mem_wstrb_q, st_wstrb;
  logic err_q, kill_q, mem_we_q;
  logic is_st, half, word, acc, mis, start, kill, capture;
  dt1_lsu_align u_align (
    .mem_write_i (MemWriteM),
    .st_addr_i   (ALUResultM[1:0]),
    .wdata_i     (WriteDataM),
    .ld_addr_i   (a_q),
    .ld_size_i   (size_q),
    .rdata_i     (mem_rdata),
    .wstrb_o     (st_wstrb),
    .wdata_o     (st_wdata),
    .rdata_o     (ld_data)
  );
  always_comb begin
    is_st = MemWriteM != MEM_NONE;
    half = is_st ? MemWriteM == MEM_SH : LoadSizeM[1:0] == 2'b01;
    word = is_st ? MemWriteM == MEM_SW : LoadSizeM[1:0] != 2'b01 && LoadSizeM[1:0] != 2'b00;
    acc = (is_st | LoadM) & ~FlushM;
    mis = half & ALUResultM[0] | word & (|ALUResultM[1:0]);
    start = state_q == IDLE & acc & ~mis;
    kill = kill_q | FlushM;
    state_d = state_q == IDLE ? (start ? REQ : IDLE) :
              state_q == REQ  ? (FlushM ? IDLE : mem_gnt ? (mem_rvalid ? DONE : RESP) : REQ) :
              state_q == RESP ? (mem_rvalid | cnt_q == CW'(TIMEOUT) ? DONE : RESP) : IDLE;
    capture = state_d == DONE;
    cnt_d = state_d != RESP ? '0 : state_q == RESP ? cnt_q + 1'b1 : CW'(1);
    MisalignM = state_q == IDLE & acc & mis;
    StallM = start | state_q == REQ | state_q == RESP;
    done_o = state_q == DONE & ~kill;
    BusErrM = done_o & err_q;
    ReadDataM = done_o ? rdata_q : '0;
  end
  assign mem_req   = state_q == REQ;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      size_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      kill_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= state_q == RESP & kill;
      if (start) begin
        mem_we_q    <= is_st;
        mem_addr_q  <= {ALUResultM[XLEN-1:2], 2'b00};
        mem_wdata_q <= st_wdata;
        mem_wstrb_q <= st_wstrb;
        a_q         <= ALUResultM[1:0];
        size_q      <= LoadSizeM;
      end
      if (capture) begin
        rdata_q <= mem_rvalid & ~mem_we_q & ~mem_err ? ld_data : '0;
        err_q   <= ~mem_rvalid | mem_err;
      end
    end
  end
endmodule
